peak_detector: RTL and testbench
================================

// Module: peak_detector
// PURPOSE
//  Consumes the per-clock filtered sample stream from v2_filter (output_data_v2).
//  Finds threshold-crossing pulses and tracks the maximum within each pulse.
//  Emits one event per pulse: peak amplitude, peak timestamp, pulse length and flags.
//  Events leave through a valid/ready port to the readout stage.
// PARAMETERS
//  DATA_W   SIZE_FILTER_DATA+3  width of the signed filtered sample (matches output_data_v2)
//  TS_W     SIZE_TIMESTAMP(32)  width of the free-running timestamp
//  LEN_W    8                   pulse-length counter width; MAX_LEN = 2**LEN_W-1
//  HYST     4                   falling hysteresis in LSB; pulse ends when x < thr-HYST
// PORTS
//  clk          in   1       system clock
//  reset        in   1       asynchronous, active-low reset
//  input_data   in   DATA_W  signed two's-complement filtered sample, new value every clk
//  threshold    in   DATA_W  signed start threshold; latched at pulse start
//  enable       in   1       1 = new pulses may start
//  out_valid    out  1       event available
//  out_ready    in   1       consumer accepts event when out_valid&&out_ready
//  peak_amp     out  DATA_W  signed maximum sample of the pulse
//  peak_time    out  TS_W    timestamp of the first sample equal to the maximum
//  pulse_len    out  LEN_W   number of samples with x above the end level, saturating
//  truncated    out  1       pulse reached MAX_LEN before falling
//  lost_cnt     out  16      events dropped because the slot was full; saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset (reset=0, async): all outputs 0, state IDLE, ts=0, lost_cnt=0.
//  - ts: increments every clk, wraps 2**TS_W-1 -> 0; a sample is stamped with ts of the clk it is sampled on.
//  - All compares are signed; thr-HYST is computed in DATA_W+1 bits (no wrap).
//  - FSM:
//    - IDLE: enable && x>threshold -> TRACK.
//      Latch thr_l=threshold, max=x, tmax=ts, len=1.
//    - TRACK, normal sample: len++; if x>max (strict) then max=x, tmax=ts.
//      Ties keep the earliest sample.
//    - TRACK, end (x < thr_l-HYST): the ending sample is not counted. Emit event -> IDLE.
//    - TRACK, len==MAX_LEN and not ending: emit with truncated=1 -> HOLDOFF.
//    - HOLDOFF: x < thr_l-HYST -> IDLE. No new pulse can start while in HOLDOFF.
//  - Emit: the event is registered, so out_valid rises the clk after the end/truncation sample (latency 1).
//    From IDLE, a new pulse may start on the very next sample.
//  - Slot: one-deep holding register.
//    - out_valid and data are held stable until the handshake.
//    - Accept and load in the same clk is allowed: the slot reloads and out_valid stays 1.
//    - Emit while the slot is full and not accepted: the new event is dropped and lost_cnt++. The held event is untouched.
//  - enable falling during TRACK: the current pulse completes normally. It only gates pulse starts.
//  - threshold changes mid-pulse: ignored until the next start.
//  - reset mid-pulse: the pulse is discarded and the slot is cleared, with no event.
// STRUCTURE
//  - package_settings gains:
//    - SIZE_TIMESTAMP
//    - typedef enum {IDLE,TRACK,HOLDOFF} peak_state_t
//    - typedef struct packed peak_event_t {amp,time,len,truncated}
//  - Sub-module peak_event_slot: one-deep valid/ready holding register with drop/lost-count logic.
//  - Top level: ts counter, FSM, max tracker.
// TESTING
//  1. reset=0 mid-stream -> all outputs 0 within the same clk. After release, ts starts at 0.
//  2. thr=100, HYST=4, pulse 50,120,300,300,200,90,50 with out_ready=1:
//     one event, amp=300, peak_time=ts of the first 300, len=4, truncated=0, out_valid 1 clk after the 90.
//  3. thr=100, input held at 500 for 300 clks then 0 (LEN_W=8):
//     event len=255, truncated=1; no second event until input<96.
//  4. out_ready=0, two separated pulses -> first event held, lost_cnt=1.
//     Then out_ready=1 -> first event accepted, out_valid=0.
//  5. Event accepted in the same clk a new event is emitted -> out_valid stays 1, new data, lost_cnt unchanged.
//  6. Negative threshold -200 with negative samples -> signed compare. enable=0 -> no event. Sample at thr-HYST exactly -> pulse not ended.

Source files
------------

// File: rtl/peak_detector_pkg.sv
// Shared widths, FSM state encoding and event layout for the peak detector.
// Filtered samples are SIZE_FILTER_DATA+3 bits wide, matching output_data_v2.
package peak_detector_pkg;

    localparam int SIZE_FILTER_DATA = 13;
    localparam int SIZE_TIMESTAMP   = 32;

    localparam int PD_DATA_W = SIZE_FILTER_DATA + 3;
    localparam int PD_TS_W   = SIZE_TIMESTAMP;
    localparam int PD_LEN_W  = 8;
    localparam int PD_HYST   = 4;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HOLDOFF
    } peak_state_t;

    // Field order matches the packed event vector handed to peak_event_slot.
    typedef struct packed {
        logic signed [PD_DATA_W-1:0] amp;
        logic [PD_TS_W-1:0]          peak_time;
        logic [PD_LEN_W-1:0]         len;
        logic                        truncated;
    } peak_event_t;

endpackage

// File: rtl/peak_event_slot.sv
// One-deep valid/ready holding register for peak events.
// A load into a full, unaccepted slot is dropped and counted in lost_cnt.
module peak_event_slot #(
    parameter int EV_W = 57
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_valid,
    input  logic [EV_W-1:0] load_data,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [EV_W-1:0] out_data,
    output logic [15:0]     lost_cnt
);

    logic can_load;

    // The slot can take a new event when empty or when the held one leaves this clk.
    assign can_load = !out_valid || out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            lost_cnt  <= '0;
        end else if (load_valid) begin
            if (can_load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
            end else if (lost_cnt != 16'hFFFF) begin
                lost_cnt <= lost_cnt + 16'd1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/peak_detector.sv
// Threshold-crossing pulse detector: tracks the maximum of each pulse and emits
// one event (amplitude, timestamp, length, truncation flag) per pulse.
module peak_detector
    import peak_detector_pkg::*;
#(
    parameter int DATA_W = PD_DATA_W,
    parameter int TS_W   = PD_TS_W,
    parameter int LEN_W  = PD_LEN_W,
    parameter int HYST   = PD_HYST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] input_data,
    input  logic [DATA_W-1:0] threshold,
    input  logic              enable,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] peak_amp,
    output logic [TS_W-1:0]   peak_time,
    output logic [LEN_W-1:0]  pulse_len,
    output logic              truncated,
    output logic [15:0]       lost_cnt
);

    localparam int                  EV_W    = DATA_W + TS_W + LEN_W + 1;
    localparam logic [LEN_W-1:0]    MAX_LEN = '1;
    localparam logic signed [DATA_W:0] HYST_X = HYST[DATA_W:0];

    peak_state_t              state;
    logic [TS_W-1:0]          ts;
    logic signed [DATA_W-1:0] thr_l;
    logic signed [DATA_W-1:0] max_amp;
    logic [TS_W-1:0]          max_time;
    logic [LEN_W-1:0]         len;

    logic signed [DATA_W:0]   x_ext;
    logic signed [DATA_W:0]   end_level;
    logic                     below_end;
    logic                     start;
    logic                     len_full;
    logic                     emit;
    logic [EV_W-1:0]          emit_data;
    logic [EV_W-1:0]          slot_data;

    // End level is one bit wider so thr_l-HYST cannot wrap near the negative limit.
    assign x_ext     = {input_data[DATA_W-1], input_data};
    assign end_level = {thr_l[DATA_W-1], thr_l} - HYST_X;
    assign below_end = x_ext < end_level;
    assign start     = enable && ($signed(input_data) > $signed(threshold));
    assign len_full  = (len == MAX_LEN);

    // The event goes straight into the slot register, giving one clk of latency.
    assign emit      = (state == TRACK) && (below_end || len_full);
    assign emit_data = {max_amp, max_time, len, !below_end};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            thr_l    <= '0;
            max_amp  <= '0;
            max_time <= '0;
            len      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= TRACK;
                        thr_l    <= $signed(threshold);
                        max_amp  <= $signed(input_data);
                        max_time <= ts;
                        len      <= {{(LEN_W-1){1'b0}}, 1'b1};
                    end
                end
                TRACK: begin
                    if (below_end) begin
                        state <= IDLE;
                    end else if (len_full) begin
                        state <= HOLDOFF;
                    end else begin
                        len <= len + 1'b1;
                        // Strict compare keeps the earliest of equal maxima.
                        if ($signed(input_data) > max_amp) begin
                            max_amp  <= $signed(input_data);
                            max_time <= ts;
                        end
                    end
                end
                HOLDOFF: begin
                    if (below_end) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    peak_event_slot #(
        .EV_W(EV_W)
    ) u_slot (
        .clk       (clk),
        .reset     (reset),
        .load_valid(emit),
        .load_data (emit_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (slot_data),
        .lost_cnt  (lost_cnt)
    );

    assign {peak_amp, peak_time, pulse_len, truncated} = slot_data;

endmodule

// File: tb/tb_peak_detector.sv
// Directed bench for peak_detector: a vector table for the basic pulse, signed
// and handshake cases, plus sequences for drops, truncation and mid-pulse reset.
module tb_peak_detector;
    import peak_detector_pkg::*;

    localparam int DW = PD_DATA_W;
    localparam int TW = PD_TS_W;
    localparam int LW = PD_LEN_W;

    logic          clk;
    logic          reset;
    logic [DW-1:0] input_data;
    logic [DW-1:0] threshold;
    logic          enable;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] peak_amp;
    logic [TW-1:0] peak_time;
    logic [LW-1:0] pulse_len;
    logic          truncated;
    logic [15:0]   lost_cnt;

    logic [31:0]   tb_ts;
    int            n_checks;
    int            n_fail;

    typedef struct {
        int x;
        int thr;
        bit en;
        bit rdy;
        bit v;
        int amp;
        int tm;
        int len;
        bit tr;
    } vec_t;

    vec_t vecs[18];

    peak_detector dut (
        .clk       (clk),
        .reset     (reset),
        .input_data(input_data),
        .threshold (threshold),
        .enable    (enable),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .peak_amp  (peak_amp),
        .peak_time (peak_time),
        .pulse_len (pulse_len),
        .truncated (truncated),
        .lost_cnt  (lost_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference timestamp: counts clks since reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_ts <= '0;
        else        tb_ts <= tb_ts + 32'd1;
    end

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Applies one sample, returns the timestamp it is sampled with, and leaves
    // the bench 1 time unit after the sampling edge.
    task automatic drive(input int x, output logic [31:0] stamp);
        input_data = x[DW-1:0];
        stamp = tb_ts;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int thr, input bit en, input bit rdy);
        threshold = thr[DW-1:0];
        enable    = en;
        out_ready = rdy;
    endtask

    task automatic check_event(input string tag, input int amp, input int tm,
                               input int len, input int tr);
        check({tag, " valid"}, {31'd0, out_valid}, 1);
        check({tag, " amp"}, $signed(peak_amp), amp);
        check({tag, " time"}, peak_time, tm);
        check({tag, " len"}, {24'd0, pulse_len}, len);
        check({tag, " trunc"}, {31'd0, truncated}, tr);
    endtask

    initial begin
        logic [31:0] st;
        logic [31:0] t_first;
        int          extra;

        n_checks = 0;
        n_fail   = 0;

        // Timestamps in the table are row indices: row 0 is sampled at ts 0.
        //          x     thr   en rdy v  amp   tm  len tr
        vecs[0]  = '{50,   100,  1, 1, 0, 0,    0,  0,  0};
        vecs[1]  = '{120,  100,  1, 1, 0, 0,    0,  0,  0};
        vecs[2]  = '{300,  100,  1, 1, 0, 0,    0,  0,  0};
        vecs[3]  = '{300,  100,  1, 1, 0, 0,    0,  0,  0};
        vecs[4]  = '{200,  100,  1, 1, 0, 0,    0,  0,  0};
        vecs[5]  = '{90,   100,  1, 1, 1, 300,  2,  4,  0};
        vecs[6]  = '{50,   100,  1, 1, 0, 0,    0,  0,  0};
        vecs[7]  = '{-150, -200, 0, 1, 0, 0,    0,  0,  0};
        vecs[8]  = '{-100, -200, 0, 1, 0, 0,    0,  0,  0};
        vecs[9]  = '{-150, -200, 1, 1, 0, 0,    0,  0,  0};
        vecs[10] = '{-204, -200, 1, 1, 0, 0,    0,  0,  0};
        vecs[11] = '{-120, 0,    0, 1, 0, 0,    0,  0,  0};
        vecs[12] = '{-205, 0,    0, 1, 1, -120, 11, 3,  0};
        vecs[13] = '{-300, 0,    1, 0, 1, -120, 11, 3,  0};
        vecs[14] = '{10,   0,    1, 0, 1, -120, 11, 3,  0};
        vecs[15] = '{5,    0,    1, 0, 1, -120, 11, 3,  0};
        vecs[16] = '{-10,  0,    1, 1, 1, 10,   14, 2,  0};
        vecs[17] = '{-10,  0,    1, 1, 0, 0,    0,  0,  0};

        reset      = 1'b0;
        input_data = '0;
        set_cfg(0, 0, 0);
        #1;
        check("reset valid", {31'd0, out_valid}, 0);
        check("reset lost", {16'd0, lost_cnt}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            set_cfg(vecs[i].thr, vecs[i].en, vecs[i].rdy);
            drive(vecs[i].x, st);
            check($sformatf("row%0d valid", i), {31'd0, out_valid}, {31'd0, vecs[i].v});
            check($sformatf("row%0d lost", i), {16'd0, lost_cnt}, 0);
            if (vecs[i].v) begin
                check($sformatf("row%0d amp", i), $signed(peak_amp), vecs[i].amp);
                check($sformatf("row%0d time", i), peak_time, vecs[i].tm);
                check($sformatf("row%0d len", i), {24'd0, pulse_len}, vecs[i].len);
                check($sformatf("row%0d trunc", i), {31'd0, truncated}, {31'd0, vecs[i].tr});
            end
        end

        // Two pulses with the consumer stalled: the second is dropped.
        set_cfg(100, 1, 0);
        drive(200, t_first);
        drive(200, st);
        drive(0, st);
        drive(0, st);
        drive(150, st);
        drive(0, st);
        check_event("drop held", 200, int'(t_first), 2, 0);
        check("drop lost", {16'd0, lost_cnt}, 1);
        out_ready = 1'b1;
        drive(0, st);
        check("drop accept valid", {31'd0, out_valid}, 0);
        check("drop accept lost", {16'd0, lost_cnt}, 1);

        // Long pulse saturates the length, then holds off until below thr-HYST.
        extra = 0;
        t_first = '0;
        for (int i = 0; i < 300; i++) begin
            drive(500, st);
            if (i == 0) t_first = st;
            if (i == 255) check_event("trunc", 500, int'(t_first), 255, 1);
            else if (out_valid) extra++;
        end
        check("trunc extra events", extra, 0);
        drive(96, st);
        check("holdoff at 96 valid", {31'd0, out_valid}, 0);
        drive(95, st);
        check("holdoff exit valid", {31'd0, out_valid}, 0);
        drive(150, t_first);
        drive(0, st);
        check_event("after holdoff", 150, int'(t_first), 1, 0);
        check("after holdoff lost", {16'd0, lost_cnt}, 1);
        drive(0, st);

        // Reset in the middle of a held event clears everything at once.
        out_ready = 1'b0;
        drive(200, st);
        drive(0, st);
        check("pre-reset valid", {31'd0, out_valid}, 1);
        #2;
        reset = 1'b0;
        #1;
        check("async reset valid", {31'd0, out_valid}, 0);
        check("async reset amp", $signed(peak_amp), 0);
        check("async reset time", peak_time, 0);
        check("async reset len", {24'd0, pulse_len}, 0);
        check("async reset trunc", {31'd0, truncated}, 0);
        check("async reset lost", {16'd0, lost_cnt}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        drive(150, st);
        drive(0, st);
        check_event("post-reset", 150, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
